// File: rtl/fifo_frame_arbiter_pkg.sv
// fifo_frame_arbiter_pkg: shared state encoding and fifoData field layout
package fifo_frame_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2
   } state_t;

   // fifoData = {sof, chId, payload}
   function automatic int sof_bit(int data_w, int ch_w);
      return data_w + ch_w;
   endfunction

   function automatic int ch_lsb(int data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/fifo_frame_arbiter_rr_pick.sv
// fifo_frame_arbiter_rr_pick: combinational round-robin selector starting after the last grant
module fifo_frame_arbiter_rr_pick #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] req_i,
   input  logic [CH_W-1:0] ptr_i,
   output logic [CH_W-1:0] idx_o,
   output logic            any_o
);

   // channel (ptr+k) mod N_CH, wrapped explicitly so non-power-of-two N_CH works
   function automatic logic [CH_W-1:0] wrap(logic [CH_W-1:0] ptr, int k);
      int s;
      s = int'(ptr) + k;
      return CH_W'(s >= N_CH ? s - N_CH : s);
   endfunction

   // scan farthest to nearest so the nearest requester after ptr_i wins
   always_comb begin
      idx_o = ptr_i;
      any_o = 1'b0;
      for (int k = N_CH; k >= 1; k--) begin
         if (req_i[wrap(ptr_i, k)]) begin
            idx_o = wrap(ptr_i, k);
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_frame_arbiter.sv
// fifo_frame_arbiter: frame-atomic round-robin write arbiter with credit-based FIFO flow control
module fifo_frame_arbiter
   import fifo_frame_arbiter_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int CH_W      = 2,
   parameter int DATA_W    = 8,
   parameter int FRAME_LEN = 16,
   parameter int FIFO_LEN  = 16,
   parameter int CRED_W    = 5
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [N_CH-1:0]          chValid,
   input  logic [N_CH*DATA_W-1:0]   chData,
   output logic [N_CH-1:0]          chReady,
   output logic                     fifoWe,
   output logic [DATA_W+CH_W:0]     fifoData,
   input  logic                     fifoRdDone,
   output logic [CH_W-1:0]          grantCh,
   output logic                     busy,
   output logic [CRED_W-1:0]        credits
);

   localparam int CNT_W   = $clog2(FRAME_LEN);
   localparam int SOF_BIT = sof_bit(DATA_W, CH_W);
   localparam int CH_LSB  = ch_lsb(DATA_W);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

   state_t            state_q, state_d;
   logic [CH_W-1:0]   grant_q, grant_d, pick;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CRED_W-1:0] cred_q, cred_d;
   logic              any_req, can_wr, wr;
   logic [DATA_W-1:0] ch_word [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_word
      assign ch_word[i] = chData[i*DATA_W +: DATA_W];
   end

   fifo_frame_arbiter_rr_pick #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr_pick (
      .req_i (chValid),
      .ptr_i (grant_q),
      .idx_o (pick),
      .any_o (any_req)
   );

   assign can_wr  = state_q == ST_XFER && cred_q != '0;
   assign wr      = can_wr && chValid[grant_q];
   assign fifoWe  = wr;
   assign busy    = state_q != ST_IDLE;
   assign grantCh = grant_q;
   assign credits = cred_q;
   assign fifoData[SOF_BIT]          = cnt_q == '0;
   assign fifoData[CH_LSB +: CH_W]   = grant_q;
   assign fifoData[DATA_W-1:0]       = ch_word[grant_q];

   // only the granted channel may be ready, and only while a FIFO slot is free
   always_comb begin
      chReady = '0;
      chReady[grant_q] = can_wr;
   end

   // a write consumes a slot, a consumer read returns one; saturate at the usable capacity
   assign cred_d = (wr && !fifoRdDone) ? cred_q - 1'b1 :
                   (!wr && fifoRdDone && cred_q != CRED_MAX) ? cred_q + 1'b1 : cred_q;

   // next-state: pick a channel in IDLE, bubble in GRANT, move one full frame in XFER
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            cnt_d   = '0;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (wr) begin
               cnt_d   = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
               state_d = cnt_q == CNT_LAST ? ST_IDLE : ST_XFER;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, grant pointer, word counter and credit registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         grant_q <= CH_W'(N_CH - 1);
         cnt_q   <= '0;
         cred_q  <= CRED_MAX;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         cred_q  <= cred_d;
      end
   end

   // a read completion while the FIFO is known empty breaks the credit protocol
   rd_on_empty: assert property (@(posedge Clk) disable iff (Rst) !(fifoRdDone && cred_q == CRED_MAX));

endmodule

// File: tb/tb_fifo_frame_arbiter.sv
// tb_fifo_frame_arbiter: directed vector table plus multi-cycle sequences for the frame arbiter
module tb_fifo_frame_arbiter;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [3:0]  chValid = '0;
   logic [31:0] chData = '0;
   logic [3:0]  chReady;
   logic        fifoWe;
   logic [10:0] fifoData;
   logic        fifoRdDone = 1'b0;
   logic [1:0]  grantCh;
   logic        busy;
   logic [4:0]  credits;

   always #5 Clk = ~Clk;

   fifo_frame_arbiter #(
      .N_CH      (4),
      .CH_W      (2),
      .DATA_W    (8),
      .FRAME_LEN (16),
      .FIFO_LEN  (16),
      .CRED_W    (5)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .chValid    (chValid),
      .chData     (chData),
      .chReady    (chReady),
      .fifoWe     (fifoWe),
      .fifoData   (fifoData),
      .fifoRdDone (fifoRdDone),
      .grantCh    (grantCh),
      .busy       (busy),
      .credits    (credits)
   );

   typedef struct {
      bit sof;
      int ch;
      int data;
      int cyc;
   } wr_t;

   typedef struct {
      logic [3:0] valid;
      logic       rd;
      logic       we;
      logic [3:0] ready;
      logic [1:0] grant;
      logic       busy;
      logic [4:0] cred;
      logic       sof;
   } vec_t;

   int  checks = 0;
   int  errors = 0;
   int  occ = 0;
   int  cyc = 0;
   int  src_cnt [4];
   bit  drain = 0;
   wr_t log_q [$];
   vec_t tbl [7];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // sample the cycle at negedge, then present next source words and FIFO reads after the edge
   task automatic tick();
      @(negedge Clk);
      if (fifoWe) log_q.push_back('{fifoData[10], int'(fifoData[9:8]), int'(fifoData[7:0]), cyc});
      for (int i = 0; i < 4; i++) if (chValid[i] && chReady[i]) src_cnt[i]++;
      occ = Rst ? 0 : occ + (fifoWe ? 1 : 0) - (fifoRdDone ? 1 : 0);
      cyc++;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 4; i++) chData[i*8 +: 8] = 8'(i * 64 + src_cnt[i] % 64);
      fifoRdDone = drain && occ > 0;
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      chValid = '0;
      fifoRdDone = 1'b0;
      drain = 0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         src_cnt[i] = 0;
         chData[i*8 +: 8] = 8'(i * 64);
      end
      Rst = 1'b0;
      log_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int cnt;
      bit ok;
      tbl[0] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 5'd15, 1'b1};
      tbl[1] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 5'd15, 1'b1};
      tbl[2] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 5'd15, 1'b1};
      tbl[3] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 5'd14, 1'b0};
      tbl[4] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 5'd14, 1'b0};
      tbl[5] = '{4'b0000, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 5'd14, 1'b0};
      tbl[6] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 5'd15, 1'b0};

      for (int i = 0; i < 4; i++) src_cnt[i] = 0;
      do_reset();
      Rst = 1'b1;
      tick();
      chk("rst_grant", grantCh, 3);
      chk("rst_credits", credits, 15);
      chk("rst_busy", busy, 0);
      chk("rst_ready", chReady, 0);
      chk("rst_we", fifoWe, 0);
      Rst = 1'b0;

      // single channel: latency, credits, stall, and first-word tagging
      for (int i = 0; i < 7; i++) begin
         chValid = tbl[i].valid;
         fifoRdDone = tbl[i].rd;
         #1;
         chk($sformatf("vec%0d_we", i), fifoWe, tbl[i].we);
         chk($sformatf("vec%0d_ready", i), chReady, tbl[i].ready);
         chk($sformatf("vec%0d_grant", i), grantCh, tbl[i].grant);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("vec%0d_credits", i), credits, tbl[i].cred);
         chk($sformatf("vec%0d_sof", i), fifoData[10], tbl[i].sof);
         tick();
      end
      drain = 1;
      fifoRdDone = occ > 0;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("single_timeout", n < 100, 1);
      chk("single_writes", log_q.size(), 16);
      chk("single_busy_end", busy, 0);
      chk("single_grant_end", grantCh, 1);
      cnt = 0;
      ok = 1;
      foreach (log_q[j]) begin
         if (log_q[j].sof) cnt++;
         if (log_q[j].ch != 1 || log_q[j].data != 64 + j) ok = 0;
      end
      chk("single_sof_count", cnt, 1);
      chk("single_sof_first", log_q.size() > 0 ? log_q[0].sof : 0, 1);
      chk("single_ch_data", ok, 1);
      chValid = '0;

      // round-robin: all channels request, frames 0,1,2,3,0
      do_reset();
      chValid = 4'hf;
      drain = 1;
      n = 0;
      while (log_q.size() < 80 && n < 600) begin tick(); n++; end
      chk("rr_timeout", n < 600, 1);
      if (log_q.size() >= 80) begin
         for (int k = 0; k < 5; k++) begin
            ok = 1;
            for (int j = 0; j < 16; j++) begin
               wr_t e;
               e = log_q[k*16 + j];
               if (e.ch != k % 4 || e.sof != (j == 0) || e.data != (k % 4) * 64 + (k / 4) * 16 + j) ok = 0;
               if (j > 0 && e.cyc != log_q[k*16 + j - 1].cyc + 1) ok = 0;
            end
            chk($sformatf("rr_frame%0d_ch", k), log_q[k*16].ch, k % 4);
            chk($sformatf("rr_frame%0d_contig", k), ok, 1);
            if (k > 0) chk($sformatf("rr_frame%0d_gap", k), log_q[k*16].cyc - log_q[k*16 - 1].cyc, 3);
         end
      end

      // credit exhaustion with no reads, then one read lets exactly one word through
      do_reset();
      chValid = 4'b0001;
      repeat (30) tick();
      chk("exh_writes", log_q.size(), 15);
      chk("exh_credits", credits, 0);
      chk("exh_ready", chReady, 0);
      chk("exh_busy", busy, 1);
      fifoRdDone = 1'b1;
      #1;
      chk("exh_rd_we", fifoWe, 0);
      tick();
      chk("exh_one_we", fifoWe, 1);
      chk("exh_one_ready", chReady, 4'b0001);
      tick();
      chk("exh_credits_again", credits, 0);
      repeat (6) tick();
      chk("exh_total", log_q.size(), 16);

      // simultaneous write and read leaves credits unchanged
      chValid = '0;
      repeat (5) begin fifoRdDone = 1'b1; tick(); end
      chk("sim_pre_credits", credits, 5);
      chValid = 4'b0001;
      fifoRdDone = 1'b1;
      #1;
      chk("sim_we", fifoWe, 1);
      tick();
      chk("sim_credits", credits, 5);
      tick();
      chk("sim_write_only", credits, 4);
      chValid = '0;

      // source stall mid-frame keeps the grant; other requesters wait
      do_reset();
      chValid = 4'b0100;
      drain = 1;
      n = 0;
      while (log_q.size() < 5 && n < 50) begin tick(); n++; end
      chValid = 4'b0011;
      ok = 1;
      repeat (7) begin
         tick();
         if (grantCh != 2 || !busy) ok = 0;
      end
      chk("stall_no_writes", log_q.size(), 5);
      chk("stall_held", ok, 1);
      chValid = 4'b0111;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("stall_writes", log_q.size(), 16);
      ok = 1;
      foreach (log_q[j]) if (log_q[j].ch != 2 || log_q[j].data != 128 + j) ok = 0;
      chk("stall_all_ch2", ok, 1);
      n = 0;
      while (log_q.size() < 17 && n < 20) begin tick(); n++; end
      chk("stall_next_ch", log_q.size() > 16 ? log_q[16].ch : -1, 0);

      // reset mid-frame abandons the frame and restores the pointer
      do_reset();
      chValid = 4'b1000;
      drain = 1;
      n = 0;
      while (log_q.size() < 10 && n < 50) begin tick(); n++; end
      Rst = 1'b1;
      chValid = 4'b1001;
      tick();
      chk("mrst_ready", chReady, 0);
      chk("mrst_credits", credits, 15);
      chk("mrst_grant", grantCh, 3);
      chk("mrst_busy", busy, 0);
      Rst = 1'b0;
      log_q.delete();
      n = 0;
      while (log_q.size() < 1 && n < 20) begin tick(); n++; end
      chk("mrst_first_ch", log_q.size() > 0 ? log_q[0].ch : -1, 0);
      chk("mrst_first_sof", log_q.size() > 0 ? log_q[0].sof : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
